// File: rtl/temporal_unary_decoder_if.sv
// Bundles the unary window inputs and the decoded-frame valid/ready outputs.
// The master drives windows and consumes frames; the slave is the decoder.
interface temporal_unary_decoder_if #(
    parameter int LANES     = 16,
    parameter int BIT_WIDTH = 4
) ();
    logic                       start;
    logic [LANES-1:0]           unary_in;
    logic [LANES-1:0]           sign_in;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*BIT_WIDTH-1:0] out_data;
    logic [LANES-1:0]           out_sat;
    logic [LANES-1:0]           out_err;
    logic                       busy;

    modport master (
        output start, unary_in, sign_in, out_ready,
        input  out_valid, out_data, out_sat, out_err, busy
    );

    modport slave (
        input  start, unary_in, sign_in, out_ready,
        output out_valid, out_data, out_sat, out_err, busy
    );
endinterface

// File: rtl/temporal_unary_decoder.sv
// Decodes LANES thermometer-coded windows into signed words behind a valid/ready handshake.
// Define THERMO_CHECK_EN to build per-lane thermometer-violation flags onto out_err.
module temporal_unary_decoder #(
    parameter int LANES     = 16,
    parameter int BIT_WIDTH = 4,
    parameter int CNT_W     = BIT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    temporal_unary_decoder_if.slave bus
);
    localparam int                   WINDOW    = 1 << (BIT_WIDTH - 1);
    localparam logic [BIT_WIDTH-1:0] WCNT_LAST = BIT_WIDTH'(WINDOW - 1);
    localparam logic [CNT_W-1:0]     CNT_FULL  = CNT_W'(WINDOW);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    state_e                     start_state_s;
    logic [CNT_W-1:0]           cnt_q [LANES];
    logic [CNT_W-1:0]           cnt_d [LANES];
    logic [LANES-1:0]           sign_q, sign_d;
    logic [BIT_WIDTH-1:0]       wcnt_q, wcnt_d;
    logic                       out_valid_q, out_valid_d;
    logic                       busy_q, busy_d;
    logic [LANES*BIT_WIDTH-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]           out_sat_q, out_sat_d;
    logic                       unary_zero_s, xfer_s, win_start_s, load_s;

    // Negative magnitudes map to -mag (so -WINDOW fits); +WINDOW clamps; zero never carries a sign.
    function automatic logic [BIT_WIDTH-1:0] to_signed_word(input logic [CNT_W-1:0] mag,
                                                            input logic             neg);
        logic [BIT_WIDTH-1:0] m;
        m = BIT_WIDTH'(mag);
        if (mag == {CNT_W{1'b0}}) begin
            to_signed_word = {BIT_WIDTH{1'b0}};
        end else if (neg) begin
            to_signed_word = {BIT_WIDTH{1'b0}} - m;
        end else if (mag == CNT_FULL) begin
            to_signed_word = WCNT_LAST;
        end else begin
            to_signed_word = m;
        end
    endfunction

    // State register plus all datapath and output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sign_q      <= {LANES{1'b0}};
            wcnt_q      <= {BIT_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= {(LANES*BIT_WIDTH){1'b0}};
            out_sat_q   <= {LANES{1'b0}};
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            wcnt_q      <= wcnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Next-state logic; a start in HOLD only counts when the frame transfers in the same cycle.
    always_comb begin
        unary_zero_s  = (bus.unary_in == {LANES{1'b0}});
        xfer_s        = out_valid_q & bus.out_ready;
        start_state_s = unary_zero_s ? HOLD : COLLECT;
        win_start_s   = 1'b0;
        state_d       = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    win_start_s = 1'b1;
                    state_d     = start_state_s;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (bus.start) begin
                    win_start_s = 1'b1;
                    state_d     = start_state_s;
                end else if (unary_zero_s || (wcnt_q == WCNT_LAST)) begin
                    state_d = HOLD;
                end else begin
                    state_d = COLLECT;
                end
            end
            HOLD: begin
                if (xfer_s && bus.start) begin
                    win_start_s = 1'b1;
                    state_d     = start_state_s;
                end else if (xfer_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs, registered from the next state.
    always_comb begin
        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
    end

    // Counters, sign capture and conversion; results latch only on entry into HOLD.
    always_comb begin
        sign_d     = sign_q;
        wcnt_d     = wcnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        load_s     = (state_d == HOLD) && ((state_q != HOLD) || win_start_s);
        if (win_start_s) begin
            sign_d = bus.sign_in;
            wcnt_d = BIT_WIDTH'(1);
        end else if (state_q == COLLECT) begin
            wcnt_d = wcnt_q + BIT_WIDTH'(1);
        end else begin
            wcnt_d = wcnt_q;
        end
        for (int i = 0; i < LANES; i++) begin
            if (win_start_s) begin
                cnt_d[i] = CNT_W'(bus.unary_in[i]);
            end else if (state_q == COLLECT) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(bus.unary_in[i]);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            if (load_s) begin
                out_data_d[i*BIT_WIDTH +: BIT_WIDTH] = to_signed_word(cnt_d[i], sign_d[i]);
                out_sat_d[i] = ~sign_d[i] & (cnt_d[i] == CNT_FULL);
            end else begin
                out_data_d[i*BIT_WIDTH +: BIT_WIDTH] = out_data_q[i*BIT_WIDTH +: BIT_WIDTH];
                out_sat_d[i] = out_sat_q[i];
            end
        end
    end

`ifdef THERMO_CHECK_EN
    logic [LANES-1:0] seen_zero_q, seen_zero_d;
    logic [LANES-1:0] err_q, err_d;
    logic [LANES-1:0] out_err_q, out_err_d;

    // Thermometer tracking flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_zero_q <= {LANES{1'b0}};
            err_q       <= {LANES{1'b0}};
            out_err_q   <= {LANES{1'b0}};
        end else begin
            seen_zero_q <= seen_zero_d;
            err_q       <= err_d;
            out_err_q   <= out_err_d;
        end
    end

    // A 1 after a 0 in the same window flags the lane; the bit is still counted above.
    always_comb begin
        seen_zero_d = seen_zero_q;
        err_d       = err_q;
        out_err_d   = out_err_q;
        if (win_start_s) begin
            seen_zero_d = ~bus.unary_in;
            err_d       = {LANES{1'b0}};
        end else if (state_q == COLLECT) begin
            err_d       = err_q | (bus.unary_in & seen_zero_q);
            seen_zero_d = seen_zero_q | ~bus.unary_in;
        end else begin
            err_d = err_q;
        end
        if (load_s) begin
            out_err_d = err_d;
        end else if (win_start_s) begin
            out_err_d = {LANES{1'b0}};
        end else begin
            out_err_d = out_err_q;
        end
    end

    assign bus.out_err = out_err_q;
`else
    assign bus.out_err = {LANES{1'b0}};
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
endmodule
